// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Bus-master front end for the 4-register ALU peripheral. The CPU stages
// operands and an opcode, pushes whole commands into a command FIFO, and an
// FSM replays each command onto the ALU port (A, B, opcode), reads the result
// back and stores it in a result FIFO that the CPU drains at its own pace.
//
// Optional build macro: ALU_SEQ_CHAIN_EN
//   When defined, a last_result register holds the most recent ALU result, and
//   a command whose opcode bit 7 is set feeds last_result to the ALU as A.
//
// Handshake: CPU strobes (data_write, data_read) are single-cycle and always
// accepted; there is no ready. A push into a full command FIFO is dropped and
// sets cmd_ovf, a pop from an empty result FIFO is a no-op that sets res_udf.
// Both flags are sticky until cleared through the status register.
module alu_op_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic       data_read,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [3:0] alu_address,
    output logic       alu_data_write,
    output logic [7:0] alu_data_in,
    input  logic [7:0] alu_data_out,
    output logic       busy
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0] CMD_MAX = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0] RES_MAX = (RAW+1)'(RES_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_A   = 3'd1,
        WR_B   = 3'd2,
        WR_OPC = 3'd3,
        RD_RES = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [7:0]  stage_a, stage_b, stage_op;
    logic        cmd_ovf, res_udf;

    logic [23:0] cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wp, cmd_rp;
    logic [CAW:0]   cmd_cnt;

    logic [7:0]  res_mem [RES_DEPTH];
    logic [RAW-1:0] res_wp, res_rp;
    logic [RAW:0]   res_cnt, res_cnt_nxt;

    logic cmd_full, cmd_empty, res_full, res_empty;
    logic cpu_push, cmd_push_ok, cmd_pop;
    logic res_pop_req, res_pop_ok, res_push;
    logic [7:0] head_a, head_b, head_op, wr_a_data;

    assign cmd_full  = (cmd_cnt == CMD_MAX);
    assign cmd_empty = (cmd_cnt == '0);
    assign res_full  = (res_cnt == RES_MAX);
    assign res_empty = (res_cnt == '0);

    assign cpu_push    = data_write && (address == 4'h2);
    assign cmd_push_ok = cpu_push && !cmd_full;
    assign cmd_pop     = (state == WR_OPC);
    assign res_pop_req = data_read && (address == 4'h3);
    assign res_pop_ok  = res_pop_req && !res_empty;
    assign res_push    = (state == RD_RES);

    assign {head_a, head_b, head_op} = cmd_mem[cmd_rp];
    assign busy = (state != IDLE) || !cmd_empty;

`ifdef ALU_SEQ_CHAIN_EN
    logic [7:0] last_result;

    // Remember every result pushed so a chained command can reuse it as A
    always_ff @(posedge clk) begin
        if (rst) begin
            last_result <= 8'h00;
        end else if (res_push) begin
            last_result <= alu_data_out;
        end
    end

    assign wr_a_data = head_op[7] ? last_result : head_a;
`else
    assign wr_a_data = head_a;
`endif

    // CPU staging registers; they persist after a push so they can be reused
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_a  <= 8'h00;
            stage_b  <= 8'h00;
            stage_op <= 8'h00;
        end else if (data_write) begin
            case (address)
                4'h0:    stage_a  <= data_in;
                4'h1:    stage_b  <= data_in;
                4'h2:    stage_op <= data_in;
                default: ;
            endcase
        end
    end

    // Sticky error flags, cleared by writing 1 to bit 0 of the status register
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ovf <= 1'b0;
            res_udf <= 1'b0;
        end else if (data_write && (address == 4'h4) && data_in[0]) begin
            cmd_ovf <= 1'b0;
            res_udf <= 1'b0;
        end else begin
            if (cpu_push && cmd_full)       cmd_ovf <= 1'b1;
            if (res_pop_req && res_empty)   res_udf <= 1'b1;
        end
    end

    // Command FIFO storage: the opcode write carries the opcode straight in
    always_ff @(posedge clk) begin
        if (cmd_push_ok) cmd_mem[cmd_wp] <= {stage_a, stage_b, data_in};
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push_ok) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop)     cmd_rp <= cmd_rp + 1'b1;
            case ({cmd_push_ok, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Result occupancy after this cycle's push/pop, used to decide back-to-back runs
    always_comb begin
        res_cnt_nxt = res_cnt;
        if (res_push && !res_pop_ok)      res_cnt_nxt = res_cnt + 1'b1;
        else if (!res_push && res_pop_ok) res_cnt_nxt = res_cnt - 1'b1;
    end

    // Result FIFO storage: the ALU read-back is captured at the end of RD_RES
    always_ff @(posedge clk) begin
        if (res_push) res_mem[res_wp] <= alu_data_out;
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (res_push)   res_wp <= res_wp + 1'b1;
            if (res_pop_ok) res_rp <= res_rp + 1'b1;
            res_cnt <= res_cnt_nxt;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and ALU bus drive; a run only starts when its result has room
    always_comb begin
        state_nxt      = state;
        alu_address    = 4'h3;
        alu_data_write = 1'b0;
        alu_data_in    = 8'h00;
        case (state)
            IDLE: begin
                if (!cmd_empty && !res_full) state_nxt = WR_A;
            end
            WR_A: begin
                alu_address    = 4'h0;
                alu_data_write = 1'b1;
                alu_data_in    = wr_a_data;
                state_nxt      = WR_B;
            end
            WR_B: begin
                alu_address    = 4'h1;
                alu_data_write = 1'b1;
                alu_data_in    = head_b;
                state_nxt      = WR_OPC;
            end
            WR_OPC: begin
                alu_address    = 4'h2;
                alu_data_write = 1'b1;
                alu_data_in    = head_op;
                state_nxt      = RD_RES;
            end
            RD_RES: begin
                if (!cmd_empty && (res_cnt_nxt < RES_MAX)) state_nxt = WR_A;
                else                                        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CPU read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0: data_out = stage_a;
            4'h1: data_out = stage_b;
            4'h2: data_out = stage_op;
            4'h3: data_out = res_empty ? 8'h00 : res_mem[res_rp];
            4'h4: data_out = {cmd_full, cmd_empty, res_full, res_empty,
                              busy, cmd_ovf, res_udf, 1'b0};
            4'h5: data_out = 8'(cmd_cnt);
            4'h6: data_out = 8'(res_cnt);
            default: data_out = 8'h00;
        endcase
    end

endmodule
